// File: rtl/mouse_stim_gen.sv
// Scripted pointer stimulus: waits at the origin, walks a selectable trajectory,
// then clicks the left button and pulses done.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; position holds its last value
// WAIT    | pointer parked at (0,0) for WAIT_CYC cycles
// MOVE    | one position update per cycle along the latched trajectory
// PRESS   | position held, mouse_left high for CLICK_CYC cycles
// RELEASE | one cycle, mouse_left low, done pulsed
module mouse_stim_gen #(
    parameter int XW        = 12,
    parameter int X_MAX     = 1023,
    parameter int Y_MAX     = 767,
    parameter int WAIT_CYC  = 2000,
    parameter int STEP      = 1,
    parameter int CLICK_CYC = 16
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    mode,
    output logic [XW-1:0] mouse_xpos,
    output logic [XW-1:0] mouse_ypos,
    output logic          mouse_left,
    output logic          busy,
    output logic          done
);

    localparam int CNT_MAX = (WAIT_CYC > CLICK_CYC) ? WAIT_CYC : CLICK_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [XW-1:0] X_LIM  = XW'(X_MAX);
    localparam logic [XW-1:0] Y_LIM  = XW'(Y_MAX);
    localparam logic [XW-1:0] STEP_N = XW'(STEP);
    localparam logic [XW:0]   STEP_W = (XW+1)'(STEP);

    localparam logic [1:0] M_DIAG  = 2'd0;
    localparam logic [1:0] M_HORIZ = 2'd1;
    localparam logic [1:0] M_RECT  = 2'd2;
    localparam logic [1:0] M_DRAG  = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        MOVE    = 3'd2,
        PRESS   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt_r, cnt_next;
    logic [1:0]    mode_r, mode_next;
    logic [1:0]    side_r, side_next;
    logic [XW-1:0] x_next, y_next;
    logic          left_next, done_next;

    logic [XW:0]   x_sum, y_sum;
    logic [XW-1:0] x_inc, y_inc, x_dec, y_dec;

    // Updates are formed one bit wider so an overshoot past the limit clamps instead of wrapping.
    always_comb begin
        x_sum = {1'b0, mouse_xpos} + STEP_W;
        y_sum = {1'b0, mouse_ypos} + STEP_W;
        x_inc = (x_sum > {1'b0, X_LIM}) ? X_LIM : x_sum[XW-1:0];
        y_inc = (y_sum > {1'b0, Y_LIM}) ? Y_LIM : y_sum[XW-1:0];
        x_dec = (mouse_xpos < STEP_N) ? '0 : mouse_xpos - STEP_N;
        y_dec = (mouse_ypos < STEP_N) ? '0 : mouse_ypos - STEP_N;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt_r      <= '0;
            mode_r     <= '0;
            side_r     <= '0;
            mouse_xpos <= '0;
            mouse_ypos <= '0;
            mouse_left <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            cnt_r      <= cnt_next;
            mode_r     <= mode_next;
            side_r     <= side_next;
            mouse_xpos <= x_next;
            mouse_ypos <= y_next;
            mouse_left <= left_next;
            done       <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt_r;
        mode_next  = mode_r;
        side_next  = side_r;
        x_next     = mouse_xpos;
        y_next     = mouse_ypos;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = WAIT;
                    mode_next  = mode;
                    side_next  = 2'd0;
                    cnt_next   = CW'(WAIT_CYC - 1);
                    x_next     = '0;
                    y_next     = '0;
                end
            end
            WAIT: begin
                if (cnt_r == '0) state_next = MOVE;
                else             cnt_next   = cnt_r - CW'(1);
            end
            MOVE: begin
                case (mode_r)
                    M_HORIZ: begin
                        x_next = x_inc;
                        y_next = '0;
                        if (x_inc == X_LIM) state_next = PRESS;
                    end
                    M_RECT: begin
                        // side_r: 0 right along top, 1 down, 2 left along bottom, 3 up
                        case (side_r)
                            2'd0: begin
                                x_next = x_inc;
                                if (x_inc == X_LIM) side_next = 2'd1;
                            end
                            2'd1: begin
                                y_next = y_inc;
                                if (y_inc == Y_LIM) side_next = 2'd2;
                            end
                            2'd2: begin
                                x_next = x_dec;
                                if (x_dec == '0) side_next = 2'd3;
                            end
                            default: begin
                                y_next = y_dec;
                                if (y_dec == '0) state_next = PRESS;
                            end
                        endcase
                    end
                    default: begin
                        x_next = x_inc;
                        y_next = y_inc;
                        if (x_inc == X_LIM && y_inc == Y_LIM) state_next = PRESS;
                    end
                endcase
                if (state_next == PRESS) cnt_next = CW'(CLICK_CYC - 1);
            end
            PRESS: begin
                if (cnt_r == '0) state_next = RELEASE;
                else             cnt_next   = cnt_r - CW'(1);
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase

        left_next = (state_next == PRESS) ||
                    (state_next == MOVE && mode_next == M_DRAG);
        done_next = (state_next == RELEASE);
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mouse_stim_gen.sv
// Directed bench for mouse_stim_gen: table of whole-run vectors plus
// hand-written sequences for per-cycle trajectories, protocol and reset abort.
module tb_mouse_stim_gen;

    logic        pclk;
    logic        rst_n;
    logic        start_a, start_b;
    logic [1:0]  mode_a, mode_b;
    logic [11:0] xa, ya, xb, yb;
    logic        la, lb, ba, bb, da, db;

    mouse_stim_gen #(.XW(12), .X_MAX(15), .Y_MAX(7), .WAIT_CYC(4), .STEP(1), .CLICK_CYC(3)) dut_a (
        .pclk(pclk), .rst_n(rst_n), .start(start_a), .mode(mode_a),
        .mouse_xpos(xa), .mouse_ypos(ya), .mouse_left(la), .busy(ba), .done(da)
    );

    mouse_stim_gen #(.XW(12), .X_MAX(15), .Y_MAX(7), .WAIT_CYC(4), .STEP(4), .CLICK_CYC(3)) dut_b (
        .pclk(pclk), .rst_n(rst_n), .start(start_b), .mode(mode_b),
        .mouse_xpos(xb), .mouse_ypos(yb), .mouse_left(lb), .busy(bb), .done(db)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    int checks = 0;
    int errors = 0;

    logic [11:0] xs [256];
    logic [11:0] ys [256];
    logic        ls [256];
    logic        bs [256];
    logic        ds [256];
    int          len;

    typedef struct {
        int         sel;
        logic [1:0] m;
        int         busy;
        int         moves;
        int         left;
        int         fx;
        int         fy;
    } vec_t;

    vec_t vecs [6];
    int   nb, nm, nl, nd, di;
    bit   seen;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic sample(input int sel, input int i);
        if (sel == 0) begin
            xs[i] = xa; ys[i] = ya; ls[i] = la; bs[i] = ba; ds[i] = da;
        end else begin
            xs[i] = xb; ys[i] = yb; ls[i] = lb; bs[i] = bb; ds[i] = db;
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [1:0] m);
        if (sel == 0) begin start_a = s; mode_a = m; end
        else          begin start_b = s; mode_b = m; end
    endtask

    // Sample i is taken 1 time unit after edge i, where edge 0 is the start edge.
    task automatic capture(input int sel, input logic [1:0] m, input bit disturb);
        @(negedge pclk);
        drive(sel, 1'b1, m);
        len = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge pclk);
            #1;
            sample(sel, i);
            len = i + 1;
            if (i > 0 && bs[i] == 1'b0) break;
            @(negedge pclk);
            drive(sel, disturb && (i == 2 || i == 8), (disturb && i >= 2) ? 2'd2 : m);
        end
        drive(sel, 1'b0, m);
        chk("capture_end_idle", int'(bs[len-1]), 0);
    endtask

    function automatic int find_pos(input int x, input int y, input int from);
        for (int i = from; i < len; i++)
            if (int'(xs[i]) == x && int'(ys[i]) == y) return i;
        return -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{sel: 0, m: 2'd0, busy: 23, moves: 15, left: 3,  fx: 15, fy: 7};
        vecs[1] = '{sel: 0, m: 2'd1, busy: 23, moves: 15, left: 3,  fx: 15, fy: 0};
        vecs[2] = '{sel: 0, m: 2'd2, busy: 52, moves: 44, left: 3,  fx: 0,  fy: 0};
        vecs[3] = '{sel: 0, m: 2'd3, busy: 23, moves: 15, left: 18, fx: 15, fy: 7};
        vecs[4] = '{sel: 1, m: 2'd1, busy: 12, moves: 4,  left: 3,  fx: 15, fy: 0};
        vecs[5] = '{sel: 1, m: 2'd0, busy: 12, moves: 4,  left: 3,  fx: 15, fy: 7};

        rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0; mode_a = 2'd0; mode_b = 2'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_x", int'(xa), 0);
        chk("rst_y", int'(ya), 0);
        chk("rst_left", int'(la), 0);
        chk("rst_busy", int'(ba), 0);
        chk("rst_done", int'(da), 0);
        chk("rst_b_busy", int'(bb), 0);
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            capture(vecs[v].sel, vecs[v].m, 1'b0);
            nb = 0; nm = 0; nl = 0; nd = 0; di = -1;
            for (int i = 0; i < len; i++) begin
                nb += int'(bs[i]);
                nl += int'(ls[i]);
                if (ds[i]) begin nd++; di = i; end
                if (i > 0 && (xs[i] != xs[i-1] || ys[i] != ys[i-1])) nm++;
            end
            chk($sformatf("v%0d_start_busy", v), int'(bs[0]), 1);
            chk($sformatf("v%0d_start_x", v), int'(xs[0]), 0);
            chk($sformatf("v%0d_busy_cycles", v), nb, vecs[v].busy);
            chk($sformatf("v%0d_move_cycles", v), nm, vecs[v].moves);
            chk($sformatf("v%0d_left_cycles", v), nl, vecs[v].left);
            chk($sformatf("v%0d_done_count", v), nd, 1);
            chk($sformatf("v%0d_done_index", v), di, 7 + vecs[v].moves);
            chk($sformatf("v%0d_final_x", v), int'(xs[len-1]), vecs[v].fx);
            chk($sformatf("v%0d_final_y", v), int'(ys[len-1]), vecs[v].fy);
        end

        // DIAG cycle by cycle
        capture(0, 2'd0, 1'b0);
        chk("diag_len", len, 24);
        for (int i = 0; i < 24; i++) begin
            int k;
            k = (i < 5) ? 0 : i - 4;
            chk($sformatf("diag_x_%0d", i), int'(xs[i]), (k > 15) ? 15 : k);
            chk($sformatf("diag_y_%0d", i), int'(ys[i]), (k > 7) ? 7 : k);
            chk($sformatf("diag_left_%0d", i), int'(ls[i]), (i >= 19 && i <= 21) ? 1 : 0);
            chk($sformatf("diag_done_%0d", i), int'(ds[i]), (i == 22) ? 1 : 0);
            chk($sformatf("diag_busy_%0d", i), int'(bs[i]), (i <= 22) ? 1 : 0);
        end

        // RECT corners in clockwise order
        capture(0, 2'd2, 1'b0);
        chk("rect_corner_15_0", find_pos(15, 0, 1), 19);
        chk("rect_corner_15_7", find_pos(15, 7, 1), 26);
        chk("rect_corner_0_7", find_pos(0, 7, 1), 41);
        chk("rect_corner_0_0", find_pos(0, 0, 5), 48);
        chk("rect_y_on_top", int'(ys[12]), 0);
        chk("rect_x_on_right", int'(xs[23]), 15);
        chk("rect_press_start", int'(ls[48]), 1);
        chk("rect_done", int'(ds[51]), 1);

        // HORIZ with STEP=4, clamped last step
        capture(1, 2'd1, 1'b0);
        begin
            int hx [5];
            hx = '{0, 4, 8, 12, 15};
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("horiz4_x_%0d", i), int'(xs[4+i]), hx[i]);
                chk($sformatf("horiz4_y_%0d", i), int'(ys[4+i]), 0);
            end
        end
        chk("horiz4_left_before_press", int'(ls[7]), 0);
        chk("horiz4_left_press", int'(ls[8]), 1);

        // start pulses and mode change mid-run are ignored
        capture(0, 2'd0, 1'b1);
        nd = 0; nm = 0;
        for (int i = 0; i < len; i++) begin
            if (ds[i]) nd++;
            if (i > 0 && (xs[i] != xs[i-1] || ys[i] != ys[i-1])) nm++;
        end
        chk("proto_done_count", nd, 1);
        chk("proto_moves", nm, 15);
        chk("proto_mid_x", int'(xs[10]), 6);
        chk("proto_mid_y", int'(ys[10]), 6);
        chk("proto_final_x", int'(xs[len-1]), 15);
        chk("proto_final_y", int'(ys[len-1]), 7);

        // DRAG button window
        capture(0, 2'd3, 1'b0);
        chk("drag_left_wait", int'(ls[3]), 0);
        chk("drag_left_first_move", int'(ls[4]), 1);
        chk("drag_left_mid_move", int'(ls[12]), 1);
        chk("drag_left_end_press", int'(ls[21]), 1);
        chk("drag_left_release", int'(ls[22]), 0);

        // start held high restarts on the cycle after RELEASE
        @(negedge pclk);
        start_a = 1'b1; mode_a = 2'd0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge pclk);
            #1;
            if (da) begin seen = 1'b1; break; end
        end
        chk("hold_done_seen", int'(seen), 1);
        @(posedge pclk); #1;
        chk("hold_idle_busy", int'(ba), 0);
        @(posedge pclk); #1;
        chk("hold_restart_busy", int'(ba), 1);
        chk("hold_restart_x", int'(xa), 0);
        @(negedge pclk);
        start_a = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge pclk);
            #1;
            if (!ba) begin seen = 1'b1; break; end
        end
        chk("hold_second_run_ends", int'(seen), 1);

        // reset during the 5th MOVE cycle
        @(negedge pclk);
        start_a = 1'b1; mode_a = 2'd0;
        @(posedge pclk); #1;
        @(negedge pclk);
        start_a = 1'b0;
        repeat (8) @(posedge pclk);
        #1;
        chk("abort_pre_x", int'(xa), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_x", int'(xa), 0);
        chk("abort_y", int'(ya), 0);
        chk("abort_left", int'(la), 0);
        chk("abort_busy", int'(ba), 0);
        chk("abort_done", int'(da), 0);
        nd = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            nd += int'(da);
        end
        @(negedge pclk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            nd += int'(da);
        end
        chk("abort_no_done", nd, 0);

        capture(0, 2'd0, 1'b0);
        nd = 0;
        for (int i = 0; i < len; i++) nd += int'(ds[i]);
        chk("after_abort_done_count", nd, 1);
        chk("after_abort_len", len, 24);
        chk("after_abort_final_x", int'(xs[len-1]), 15);
        chk("after_abort_final_y", int'(ys[len-1]), 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
